// File: rtl/steer_pkg.sv
// Shared types and constants for the steer_en rider-presence / steering-enable controller.
package steer_pkg;

    localparam int LD_W       = 12;
    localparam int TMR_W_FAST = 15;
    localparam int TMR_W_SLOW = 26;

    localparam logic [LD_W-1:0] MIN_RIDER_WT_DEF  = 12'h200;
    localparam logic [LD_W-1:0] WT_HYSTERESIS_DEF = 12'h040;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_STEER = 2'b10
    } steer_state_e;

endpackage

// File: rtl/steer_en_if.sv
// Load-cell input strobe and steering outputs of steer_en, bundled for port connection.
interface steer_en_if;
    import steer_pkg::*;

    // ld_vld is a one-cycle strobe with no ready: the pair on lft_ld/rght_ld is taken
    // on every edge where it is high, and a newer pair simply replaces the older one.
    logic            ld_vld;
    logic [LD_W-1:0] lft_ld;
    logic [LD_W-1:0] rght_ld;
    logic            en_steer;
    logic            rider_off;

    modport master (
        output ld_vld,
        output lft_ld,
        output rght_ld,
        input  en_steer,
        input  rider_off
    );

    modport slave (
        input  ld_vld,
        input  lft_ld,
        input  rght_ld,
        output en_steer,
        output rider_off
    );

endinterface

// File: rtl/steer_tmr.sv
// Settle timer for steer_en: a W-bit up-counter with synchronous clear that saturates at all ones.
module steer_tmr #(
    parameter int W = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic full
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign full = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!full) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/steer_en.sv
// Rider-presence and steering-enable controller. Optional dbg_state port with STEER_DBG_EN.
module steer_en
    import steer_pkg::*;
#(
    parameter bit              FAST_SIM      = 1'b0,
    parameter logic [LD_W-1:0] MIN_RIDER_WT  = MIN_RIDER_WT_DEF,
    parameter logic [LD_W-1:0] WT_HYSTERESIS = WT_HYSTERESIS_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    steer_en_if.slave  bus
`ifdef STEER_DBG_EN
    ,
    output logic [1:0] dbg_state
`endif
);

    localparam int TMR_W = FAST_SIM ? TMR_W_FAST : TMR_W_SLOW;
    localparam logic [LD_W:0] ON_WT  = {1'b0, MIN_RIDER_WT};
    localparam logic [LD_W:0] OFF_WT = {1'b0, MIN_RIDER_WT} - {1'b0, WT_HYSTERESIS};

    logic [LD_W-1:0] lft_q, lft_d;
    logic [LD_W-1:0] rght_q, rght_d;
    steer_state_e    state_q, state_d;

    logic [LD_W:0]   sum;
    logic [LD_W-1:0] adiff;
    logic            rider_on;
    logic            rider_gone;
    logic            gt_1_4;
    logic            gt_15_16;
    logic            clr_tmr;
    logic            tmr_full;

    always_comb begin
        lft_d  = lft_q;
        rght_d = rght_q;
        if (bus.ld_vld) begin
            lft_d  = bus.lft_ld;
            rght_d = bus.rght_ld;
        end
    end

    // |lft - rght| taken by ordering the operands, so no sign bit has to be carried.
    always_comb begin
        sum        = {1'b0, lft_q} + {1'b0, rght_q};
        adiff      = (lft_q >= rght_q) ? (lft_q - rght_q) : (rght_q - lft_q);
        rider_on   = sum > ON_WT;
        rider_gone = sum < OFF_WT;
        gt_1_4     = {1'b0, adiff} > (sum >> 2);
        gt_15_16   = {1'b0, adiff} > (sum - (sum >> 4));
    end

    steer_tmr #(
        .W (TMR_W)
    ) u_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr_tmr),
        .full  (tmr_full)
    );

    // rider_gone is tested first in every state so leaving the platform always wins.
    always_comb begin
        state_d = state_q;
        clr_tmr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rider_on) begin
                    clr_tmr = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rider_gone) begin
                    state_d = ST_IDLE;
                end else if (gt_1_4) begin
                    clr_tmr = 1'b1;
                end else if (tmr_full) begin
                    state_d = ST_STEER;
                end
            end
            ST_STEER: begin
                if (rider_gone) begin
                    state_d = ST_IDLE;
                end else if (gt_15_16) begin
                    clr_tmr = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            lft_q   <= '0;
            rght_q  <= '0;
        end else begin
            state_q <= state_d;
            lft_q   <= lft_d;
            rght_q  <= rght_d;
        end
    end

    assign bus.en_steer  = (state_q == ST_STEER);
    assign bus.rider_off = (state_q == ST_IDLE);

`ifdef STEER_DBG_EN
    assign dbg_state = state_q;
`endif

endmodule

// File: doc/steer_en.md
# steer_en

Rider-presence and steering-enable controller. Consumes the left/right load-cell readings produced by the A2D interface and decides when a rider is on the platform and standing steadily enough for steering to be enabled. Drives `en_steer` to the balance/steer logic in the digital core and `rider_off` to the authentication block.

## Interface
**Parameters**
- `FAST_SIM`, default 0: 1 selects a 15-bit settle timer for simulation; 0 selects the 26-bit silicon timer (~1.34 s at 50 MHz).
- `MIN_RIDER_WT`, default 12'h200: summed load above which a rider is detected.
- `WT_HYSTERESIS`, default 12'h040: rider-off threshold is `MIN_RIDER_WT - WT_HYSTERESIS`.

**Ports**
- `clk` input 1: system clock. One clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ld_vld` input 1: single-cycle strobe; a new `lft_ld`/`rght_ld` pair is valid.
- `lft_ld` input 12: left load cell, unsigned.
- `rght_ld` input 12: right load cell, unsigned.
- `en_steer` output 1: steering enabled.
- `rider_off` output 1: no rider present.
- `dbg_state` output 2: present only with `STEER_DBG_EN` (see Configuration).

## Operation
- On `ld_vld`, capture `lft_ld` and `rght_ld` into holding registers `lft_q` and `rght_q`. All decisions use the held values.
- Arithmetic:
  - `sum = lft_q + rght_q`, 13 bits unsigned.
  - `diff = lft_q - rght_q`, 13 bits signed; `adiff = |diff|`, 12 bits.
- Comparisons:
  - `rider_on = sum > MIN_RIDER_WT`.
  - `rider_gone = sum < (MIN_RIDER_WT - WT_HYSTERESIS)`.
  - `gt_1_4 = adiff > (sum >> 2)`.
  - `gt_15_16 = adiff > (sum - (sum >> 4))`.
- Settle timer: free-running up-counter. It is cleared by `clr_tmr`. `tmr_full` means all ones; the counter saturates at `tmr_full`.
- States:
  - IDLE: `rider_off = 1`. If `rider_on`, clear the timer and go to WAIT.
  - WAIT:
    - `rider_gone` → IDLE.
    - Else `gt_1_4` → clear the timer and stay in WAIT.
    - Else `tmr_full` → STEER.
    - Otherwise stay in WAIT.
  - STEER: `en_steer = 1`.
    - `rider_gone` → IDLE.
    - Else `gt_15_16` → clear the timer and go to WAIT.
- Priority: `rider_gone` overrides every imbalance condition.
- Outputs are decoded from the state register, so they are glitch-free:
  - `en_steer = (state == STEER)`.
  - `rider_off = (state == IDLE)`.
- Encoding: IDLE = 2'b00, WAIT = 2'b01, STEER = 2'b10. The illegal code 2'b11 recovers to IDLE on the next edge.

## Timing
- Reset values:
  - state IDLE, timer 0, `lft_q` and `rght_q` 0.
  - `en_steer = 0`, `rider_off = 1`, `dbg_state = 2'b00`.
- Latency:
  - `ld_vld` at edge N updates the holding registers.
  - The comparisons, which are combinational, act at edge N+1.
  - Outputs change immediately after edge N+1.
- `ld_vld` asserted on consecutive cycles: each sample overwrites the last. No sample is queued.
- Timer: it counts every cycle in WAIT.
  - Entry to WAIT with `clr_tmr` gives 0 on the next cycle.
  - STEER is entered on the edge after the counter reads all ones, which is 2^15 or 2^26 cycles after the clear.
- Simultaneous `tmr_full` and `gt_1_4`: the clear wins and the block stays in WAIT.
- Asynchronous reset mid-STEER: `en_steer` drops and `rider_off` rises immediately, without waiting for a clock.

## Configuration
- Macro `STEER_DBG_EN`.
- Defined: adds the `dbg_state` output, which mirrors the state register and is intended for the DE0 LEDs.
- Undefined: the port and its logic are absent, and the behaviour is otherwise identical.

## Structure
- Package `steer_pkg`, which holds:
  - the state enum (IDLE/WAIT/STEER);
  - `TMR_W_FAST = 15` and `TMR_W_SLOW = 26`;
  - the default weight constants.
- Sub-module `steer_tmr`: parameterised-width saturating counter with `clr` input and `full` output.

## Test plan
- **Reset.** Assert `rst_n = 0` mid-run → `en_steer = 0`, `rider_off = 1` asynchronously, and state IDLE.
- **Balanced mount.** Set `FAST_SIM = 1`; drive `lft = rght = 0x180` (sum 0x300) with `ld_vld`.
  - `rider_off` falls 2 cycles after `ld_vld`.
  - `en_steer` rises 2^15 cycles later.
- **Imbalanced wait.** In WAIT, drive `lft = 0x280`, `rght = 0x080` (adiff 0x200 > 0xC0) every 1000 cycles → the timer restarts each time and `en_steer` stays 0.
  - Then drive `lft = rght = 0x180` → STEER after a full 2^15 cycles.
- **Lean-off while steering.** In STEER, drive `lft = 0x2F0`, `rght = 0x010` (adiff 0x2E0 > 0x2D0) → WAIT; `en_steer = 0` and the timer is cleared.
  - Then drive `lft = 0x2C0`, `rght = 0x040` (adiff 0x280) → remains in WAIT.
- **Hysteresis.** In STEER, drive sum 0x1F0 → stays in STEER.
  - Drive sum 0x1B0 → IDLE; `rider_off = 1` and `en_steer = 0` on the next edge.
  - Drive sum 0x1B0 together with `gt_15_16` → IDLE, not WAIT.
- **Debug port.** With `STEER_DBG_EN` defined, `dbg_state` tracks 00 → 01 → 10 across the balanced-mount scenario.
